// File: rtl/dcache_controller_if.sv
// Core load/store port and data-memory port of the data cache, bundled as one interface.
// Handshake: the core holds cpu_req/cpu_we/cpu_addr/cpu_wdata steady while cpu_stall=1; a request
// completes in the cycle cpu_stall=0. The cache holds mem_req/mem_we/mem_addr/mem_wdata steady
// until the cycle mem_ready=1, which completes that memory transaction.
interface dcache_controller_if #(
    parameter int WIDTH = 32
);
    logic             cpu_req;
    logic             cpu_we;
    logic [WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0] cpu_wdata;
    logic [WIDTH-1:0] cpu_rdata;
    logic             cpu_stall;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;

    // Cache side: slave to the core, master to memory.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Environment side: drives the core request and plays the memory.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Load hits complete with no stall; load misses and all stores wait on the memory handshake.
module dcache_controller #(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dcache_controller_if.slave   bus,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt,
    output logic [1:0]           dbg_state
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = WIDTH - INDEX_BITS - 2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [WIDTH-1:0]   data_q [LINES];

    logic [INDEX_BITS-1:0] cpu_index, lat_index;
    logic [TAG_W-1:0]      cpu_tag, lat_tag;
    logic                  cpu_hit, lat_hit;
    logic                  line_we;
    logic [WIDTH-1:0]      line_wdata;
    logic                  unused_addr_bits;

    assign cpu_index = bus.cpu_addr[INDEX_BITS+1:2];
    assign cpu_tag   = bus.cpu_addr[WIDTH-1:INDEX_BITS+2];
    assign lat_index = mem_addr_q[INDEX_BITS+1:2];
    assign lat_tag   = mem_addr_q[WIDTH-1:INDEX_BITS+2];
    assign cpu_hit   = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
    assign lat_hit   = valid_q[lat_index] && (tag_q[lat_index] == lat_tag);
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        bus.cpu_rdata = '0;
        bus.cpu_stall = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        line_we       = 1'b0;
        line_wdata    = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    if (!bus.cpu_we && cpu_hit) begin
                        bus.cpu_rdata = data_q[cpu_index];
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_ONE;
                    end else if (!bus.cpu_we) begin
                        bus.cpu_stall = 1'b1;
                        mem_addr_d    = {bus.cpu_addr[WIDTH-1:2], 2'b00};
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_ONE;
                        state_d       = RD_MISS;
                    end else begin
                        bus.cpu_stall = 1'b1;
                        mem_addr_d    = {bus.cpu_addr[WIDTH-1:2], 2'b00};
                        mem_wdata_d   = bus.cpu_wdata;
                        state_d       = WR_THRU;
                    end
                end
            end
            RD_MISS: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.cpu_rdata = bus.mem_rdata;
                    line_we       = 1'b1;
                    line_wdata    = bus.mem_rdata;
                    state_d       = IDLE;
                end else begin
                    bus.cpu_stall = 1'b1;
                end
            end
            WR_THRU: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                if (bus.mem_ready) begin
                    // Write-through updates a resident line but never allocates one.
                    line_we    = lat_hit;
                    line_wdata = mem_wdata_q;
                    state_d    = IDLE;
                end else begin
                    bus.cpu_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            if (line_we) valid_q[lat_index] <= 1'b1;
        end
    end

    // Tag and data storage need no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (rst_n && line_we) begin
            tag_q[lat_index]  <= lat_tag;
            data_q[lat_index] <= line_wdata;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: hits, misses, write-through, conflicts, reset mid-miss,
// and counter saturation on a narrow-counter instance.
module tb_dcache_controller;
  logic        clk;
  logic        rst_n;
  logic [15:0] hit_cnt, miss_cnt;
  logic [1:0]  dbg_state;
  logic [3:0]  sat_hit_cnt, sat_miss_cnt;
  logic [1:0]  sat_dbg_state;
  int          checks;
  int          failures;

  dcache_controller_if #(.WIDTH(32)) bus ();
  dcache_controller_if #(.WIDTH(32)) sat_bus ();

  dcache_controller #(.WIDTH(32), .INDEX_BITS(6), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  dcache_controller #(.WIDTH(32), .INDEX_BITS(6), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sat_bus),
    .hit_cnt(sat_hit_cnt), .miss_cnt(sat_miss_cnt), .dbg_state(sat_dbg_state)
  );

  // Narrow instance: memory answers immediately with a fixed word.
  assign sat_bus.mem_ready = sat_bus.mem_req;
  assign sat_bus.mem_rdata = 32'h5A5A_5A5A;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // One core access with a memory that answers after `delay` busy cycles of waiting.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mem_data, input int delay,
                        output logic [31:0] rdata, output int stalls, output logic req_seen,
                        output logic [31:0] maddr, output logic [31:0] mwdata, output logic mwe);
    int busy;
    bit done;
    busy = 0; done = 0; stalls = 0; req_seen = 0;
    rdata = '0; maddr = '0; mwdata = '0; mwe = 1'b0;
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      if (bus.mem_req) begin
        busy++;
        req_seen = 1'b1;
        bus.mem_ready = (busy > delay);
        bus.mem_rdata = mem_data;
      end else begin
        bus.mem_ready = 1'b0;
      end
      @(negedge clk);
      if (bus.cpu_stall) stalls++;
      else begin
        done = 1;
        rdata = bus.cpu_rdata; maddr = bus.mem_addr; mwdata = bus.mem_wdata; mwe = bus.mem_we;
      end
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic sat_load(input logic [31:0] addr);
    @(posedge clk); #1;
    sat_bus.cpu_req = 1'b1; sat_bus.cpu_we = 1'b0; sat_bus.cpu_addr = addr;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (!sat_bus.cpu_stall) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    sat_bus.cpu_req = 1'b0;
  endtask

  logic [31:0] rd, ma, mwd;
  logic        rq, mw;
  int          st;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    sat_bus.cpu_req = 1'b0; sat_bus.cpu_we = 1'b0; sat_bus.cpu_addr = '0; sat_bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_stall", bus.cpu_stall, 0);
    check_eq("rst_mem_req", bus.mem_req, 0);
    check_eq("rst_rdata", bus.cpu_rdata, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_hit_cnt", hit_cnt, 0);
    check_eq("rst_miss_cnt", miss_cnt, 0);

    // Load miss, memory ready after 3 waiting cycles.
    access(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, rd, st, rq, ma, mwd, mw);
    check_eq("t1_stalls", st, 4);
    check_eq("t1_rdata", rd, 32'hDEADBEEF);
    check_eq("t1_mem_addr", ma, 32'h100);
    check_eq("t1_mem_we", mw, 0);
    check_eq("t1_miss_cnt", miss_cnt, 1);
    check_eq("t1_idle_rdata", bus.cpu_rdata, 0);

    // Repeat load hits with no memory traffic.
    access(1'b0, 32'h103, 32'h0, 32'h0, 0, rd, st, rq, ma, mwd, mw);
    check_eq("t2_stalls", st, 0);
    check_eq("t2_rdata", rd, 32'hDEADBEEF);
    check_eq("t2_req_seen", rq, 0);
    check_eq("t2_hit_cnt", hit_cnt, 1);

    // Store to cached line updates it.
    access(1'b1, 32'h100, 32'h12345678, 32'h0, 1, rd, st, rq, ma, mwd, mw);
    check_eq("t3_stalls", st, 2);
    check_eq("t3_mem_we", mw, 1);
    check_eq("t3_mem_addr", ma, 32'h100);
    check_eq("t3_mem_wdata", mwd, 32'h12345678);
    check_eq("t3_rdata", rd, 0);
    access(1'b0, 32'h100, 32'h0, 32'h0, 0, rd, st, rq, ma, mwd, mw);
    check_eq("t3_load_stalls", st, 0);
    check_eq("t3_load_rdata", rd, 32'h12345678);
    check_eq("t3_hit_cnt", hit_cnt, 2);
    check_eq("t3_miss_cnt", miss_cnt, 1);

    // Store to uncached address does not allocate.
    access(1'b1, 32'h200, 32'hAAAA5555, 32'h0, 0, rd, st, rq, ma, mwd, mw);
    check_eq("t4_store_stalls", st, 1);
    check_eq("t4_store_addr", ma, 32'h200);
    access(1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 2, rd, st, rq, ma, mwd, mw);
    check_eq("t4_load_stalls", st, 3);
    check_eq("t4_load_rdata", rd, 32'hCAFEF00D);
    check_eq("t4_miss_cnt", miss_cnt, 2);

    // Index conflict: 0x100 and 0x200 evict each other.
    access(1'b0, 32'h100, 32'h0, 32'h12345678, 0, rd, st, rq, ma, mwd, mw);
    check_eq("t5_a_stalls", st, 1);
    check_eq("t5_a_rdata", rd, 32'h12345678);
    access(1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 0, rd, st, rq, ma, mwd, mw);
    check_eq("t5_b_stalls", st, 1);
    access(1'b0, 32'h100, 32'h0, 32'h12345678, 0, rd, st, rq, ma, mwd, mw);
    check_eq("t5_c_stalls", st, 1);
    check_eq("t5_miss_cnt", miss_cnt, 5);
    check_eq("t5_hit_cnt", hit_cnt, 2);
    // A neighbouring index is independent of index 0.
    access(1'b0, 32'h104, 32'h0, 32'h0BADF00D, 0, rd, st, rq, ma, mwd, mw);
    check_eq("t5_d_mem_addr", ma, 32'h104);
    access(1'b0, 32'h104, 32'h0, 32'h0, 0, rd, st, rq, ma, mwd, mw);
    check_eq("t5_d_hit_rdata", rd, 32'h0BADF00D);
    access(1'b0, 32'h100, 32'h0, 32'h0, 0, rd, st, rq, ma, mwd, mw);
    check_eq("t5_e_hit_rdata", rd, 32'h12345678);
    check_eq("t5_e_hit_cnt", hit_cnt, 4);

    // Reset during a read miss abandons it; a late ready is ignored.
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h300;
    @(negedge clk);
    check_eq("t6_accept_stall", bus.cpu_stall, 1);
    @(posedge clk); #1;
    check_eq("t6_busy_mem_req", bus.mem_req, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.cpu_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77777777;
    @(negedge clk);
    check_eq("t6_mem_req_after_rst", bus.mem_req, 0);
    check_eq("t6_stall_after_rst", bus.cpu_stall, 0);
    check_eq("t6_hit_cnt_rst", hit_cnt, 0);
    check_eq("t6_miss_cnt_rst", miss_cnt, 0);
    check_eq("t6_mem_addr_rst", bus.mem_addr, 0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    access(1'b0, 32'h100, 32'h0, 32'h11112222, 0, rd, st, rq, ma, mwd, mw);
    check_eq("t6_reload_stalls", st, 1);
    check_eq("t6_reload_rdata", rd, 32'h11112222);
    check_eq("t6_reload_miss_cnt", miss_cnt, 1);

    // Saturation on the 4-bit counter instance.
    for (int i = 0; i < 20; i++) sat_load((i % 2 == 0) ? 32'h100 : 32'h200);
    @(negedge clk);
    check_eq("sat_miss_cnt", sat_miss_cnt, 32'hF);
    check_eq("sat_hit_cnt_zero", sat_hit_cnt, 0);
    for (int i = 0; i < 20; i++) sat_load(32'h200);
    @(negedge clk);
    check_eq("sat_hit_cnt", sat_hit_cnt, 32'hF);
    check_eq("sat_miss_cnt_hold", sat_miss_cnt, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
